// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Captures the control decoder's bits and the decode-stage operands once per
// cycle and presents them to EX. A load in EX whose destination is read by the
// instruction in decode raises stall_o for one cycle, and a bubble is loaded
// in its place. A flush squashes the decode slot and overrides any stall.
// Saturating counters track stall and flush events.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i                      decode slot holds a real instruction
//   ALUOp_i .. MemtoReg_i        control bits from the decoder
//   RS1data_i .. PC_i, funct_i   decode operands
//   RS1addr_i, RS2addr_i, RDaddr_i  register indices
//   flush_i                      squash the decode-slot instruction
//   stall_o                      combinational: hold PC and IF/ID this cycle
//   *_o                          registered control and datapath to EX
//   stall_cnt_o, flush_cnt_o     saturating event counters

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [1:0]       ALUOp_i,
   input  logic             ALUSrc_i,
   input  logic             Branch_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic [XLEN-1:0]  RS1data_i,
   input  logic [XLEN-1:0]  RS2data_i,
   input  logic [XLEN-1:0]  Imm_i,
   input  logic [XLEN-1:0]  PC_i,
   input  logic [9:0]       funct_i,
   input  logic [4:0]       RS1addr_i,
   input  logic [4:0]       RS2addr_i,
   input  logic [4:0]       RDaddr_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             valid_o,
   output logic [1:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             Branch_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic [XLEN-1:0]  RS1data_o,
   output logic [XLEN-1:0]  RS2data_o,
   output logic [XLEN-1:0]  Imm_o,
   output logic [XLEN-1:0]  PC_o,
   output logic [9:0]       funct_o,
   output logic [4:0]       RS1addr_o,
   output logic [4:0]       RS2addr_o,
   output logic [4:0]       RDaddr_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   logic use_rs2;
   logic hz;
   logic bubble;

   // Only registered EX state and current decode inputs feed the hazard, so
   // there is no combinational path back through the decoder.
   always_comb begin
      use_rs2 = !ALUSrc_i | MemWrite_i;
      hz      = valid_i & valid_o & MemRead_o & (RDaddr_o != 5'd0) &
                ((RDaddr_o == RS1addr_i) | (use_rs2 & (RDaddr_o == RS2addr_i)));
      stall_o = hz & !flush_i;
      bubble  = flush_i | hz;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || bubble) begin
         valid_o    <= 1'b0;
         ALUOp_o    <= 2'b00;
         ALUSrc_o   <= 1'b0;
         Branch_o   <= 1'b0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         RegWrite_o <= 1'b0;
         MemtoReg_o <= 1'b0;
         RS1data_o  <= '0;
         RS2data_o  <= '0;
         Imm_o      <= '0;
         PC_o       <= '0;
         funct_o    <= '0;
         RS1addr_o  <= '0;
         RS2addr_o  <= '0;
         RDaddr_o   <= '0;
      end else begin
         // Control from an empty slot is zeroed so EX never acts on it;
         // MemtoReg is masked with RegWrite because stores leave it undefined.
         valid_o    <= valid_i;
         ALUOp_o    <= valid_i ? ALUOp_i : 2'b00;
         ALUSrc_o   <= valid_i & ALUSrc_i;
         Branch_o   <= valid_i & Branch_i;
         MemRead_o  <= valid_i & MemRead_i;
         MemWrite_o <= valid_i & MemWrite_i;
         RegWrite_o <= valid_i & RegWrite_i;
         MemtoReg_o <= valid_i & RegWrite_i & MemtoReg_i;
         RS1data_o  <= RS1data_i;
         RS2data_o  <= RS2data_i;
         Imm_o      <= Imm_i;
         PC_o       <= PC_i;
         funct_o    <= funct_i;
         RS1addr_o  <= RS1addr_i;
         RS2addr_o  <= RS2addr_i;
         RDaddr_o   <= RDaddr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (flush_i) begin
         // A flush of an empty slot is not an event worth counting.
         if (valid_i && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end else if (hz) begin
         if (stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the RISC-V core. Sits directly downstream of the control decoder: captures its control bits plus decode-stage operands each cycle and presents them to EX. Detects load-use hazards, requests a one-cycle upstream stall, inserts a bubble, and counts stalls and flushes.

## Interface
- XLEN, 32, datapath width (operands, immediate, PC)
- CNT_W, 16, width of saturating performance counters
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  decode slot holds a real instruction
- ALUOp_i  in  2  from control decoder
- ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  from control decoder; MemtoReg_i may be X
- RS1data_i, RS2data_i, Imm_i, PC_i  in  XLEN each  decode operands
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register indices
- flush_i  in  1  squash decode-slot instruction (taken branch)
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- valid_o, ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o  out  registered control to EX
- RS1data_o, RS2data_o, Imm_o, PC_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o  out  registered datapath to EX
- stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating event counters

## Operation
- Hazard: hz = valid_i & valid_o & MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (use_rs2 & RDaddr_o == RS2addr_i)).
- use_rs2 = !ALUSrc_i | MemWrite_i (R-type, branch, store). I-type ALU and loads compare rs1 only.
- stall_o = hz & !flush_i.
- Per-cycle register update, priority high to low:
  - rst_i: all outputs and counters to 0.
  - flush_i: load bubble; flush_cnt += 1 if valid_i.
  - hz: load bubble; stall_cnt += 1.
  - otherwise: capture all _i fields; valid_o <= valid_i.
- Bubble: valid_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, MemtoReg_o = 0; ALUOp_o = 00; ALUSrc_o = 0; datapath fields are don't-care but driven 0.
- X sanitising: MemtoReg_o <= MemtoReg_i & RegWrite_i. Control inputs with valid_i = 0 are captured as bubble (control zeroed).
- Counters saturate at 2^CNT_W - 1 and never wrap.

## Timing
- Capture latency 1 cycle: inputs present at edge N appear on outputs after edge N.
- stall_o is valid within the same cycle as the offending decode inputs. It depends only on registered state and current inputs, so there is no combinational loop through the decoder.
- Stall lasts exactly one cycle. The next cycle, valid_o = 0 from the bubble, so hz = 0 and the held instruction is captured normally.
- Back-to-back loads feeding each other: each dependent load stalls once. Independent instructions never stall.
- Simultaneous flush_i and hz: flush wins, stall_o = 0, stall_cnt unchanged, flush_cnt increments.
- Reset mid-stall: the next cycle has all outputs at 0 and stall_o = 0. Upstream must not depend on a stall across reset.
- All outputs are 0 out of reset, including counters.

## Test plan
- Reset: drive arbitrary inputs with rst_i = 1 for 2 cycles -> all outputs 0, stall_o = 0.
- Pass-through: R-type add (ALUOp 10, RegWrite 1, RS1data 0x11, RS2data 0x22, rd 5) -> next cycle outputs match, valid_o = 1, stall_o never asserted.
- Load-use: ld x7 followed by add x8, x7, x1 -> stall_o = 1 for one cycle. A bubble appears (valid_o = 0, RegWrite_o = 0). The add is captured the following cycle. stall_cnt_o = 1.
- x0 / rs2-only cases: ld x0 then add uses x0 -> no stall. ld x3 then addi x4, x9, 3 with RS2addr_i = 3 (imm bits) -> no stall. ld x3 then sd x3, 0(x9) -> stall.
- Flush priority: load-use hazard with flush_i = 1 the same cycle -> stall_o = 0, bubble captured, flush_cnt_o = 1, stall_cnt_o = 0.
- Saturation with CNT_W = 4: 20 consecutive load-use pairs -> stall_cnt_o stays 15. A store with MemtoReg_i = X -> MemtoReg_o = 0.
